// File: rtl/team_06_spi_rx_pkg.sv
// Shared constants and FSM state type for the ESP SPI receiver.
package team_06_spi_rx_pkg;
    localparam int BYTE_W         = 8;
    localparam int CNT_W          = 3;
    localparam int DEF_FIFO_DEPTH = 4;

    // Bit-counter value on the rise that completes a byte.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/team_06_spi_rx_fifo.sv
// Circular receive FIFO for the ESP SPI receiver (used with TEAM06_SPI_RX_FIFO_EN).
// DEPTH must be a power of two so the pointers wrap naturally.
module team_06_spi_rx_fifo
    import team_06_spi_rx_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic              empty,
    output logic              full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign dout      = r_mem[r_rp];
    assign w_do_pop  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wp] <= din;
                r_wp        <= r_wp + PW'(1);
            end
            if (w_do_pop) r_rp <= r_rp + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/team_06_spi_from_esp.sv
// SPI receiver for bytes sent by the ESP (MSB first, sampled on spiclk rise).
// Optional feature macro: TEAM06_SPI_RX_FIFO_EN selects a FIFO_DEPTH-byte FIFO;
// otherwise a single holding register buffers one byte.
module team_06_spi_from_esp
    import team_06_spi_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spiclk,
    input  logic              past_spiclk,
    input  logic              cs,
    input  logic              serial_in,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              frame_err
);
    state_t            r_state;
    state_t            w_next;
    logic [BYTE_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_overrun;
    logic              r_frame_err;
    logic              w_rise;
    logic              w_shift_en;
    logic              w_clr;
    logic              w_push;
    logic              w_fe;
    logic              w_pop;
    logic              w_full;
    logic [BYTE_W-1:0] w_byte;

    assign w_rise    = spiclk && !past_spiclk;
    assign w_byte    = {r_shift[BYTE_W-2:0], serial_in};
    assign w_pop     = rx_valid && rx_ready;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and per-cycle datapath controls; a rise coinciding with cs
    // release still completes a byte that only needed that last bit.
    always_comb begin
        w_next     = r_state;
        w_shift_en = 1'b0;
        w_clr      = 1'b0;
        w_push     = 1'b0;
        w_fe       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!cs) w_next = SHIFT;
            end
            SHIFT: begin
                if (cs) begin
                    w_next = IDLE;
                    w_clr  = 1'b1;
                    if (w_rise && r_cnt == CNT_LAST) w_push = 1'b1;
                    else if (r_cnt != '0)            w_fe   = 1'b1;
                end else if (w_rise) begin
                    w_shift_en = 1'b1;
                    if (r_cnt == CNT_LAST) w_push = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Shift register and bit counter; the counter wraps 7->0 between bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shift_en) begin
            r_shift <= w_byte;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_push && w_full && !w_pop;
            r_frame_err <= w_fe;
        end
    end

`ifdef TEAM06_SPI_RX_FIFO_EN
    logic w_empty;

    team_06_spi_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_byte),
        .dout  (rx_data),
        .empty (w_empty),
        .full  (w_full)
    );

    assign rx_valid = !w_empty;
`else
    logic [BYTE_W-1:0] r_hold;
    logic              r_valid;
    logic              w_unused_depth;

    assign w_unused_depth = ^FIFO_DEPTH;
    assign w_full         = r_valid;
    assign rx_valid       = r_valid;
    assign rx_data        = r_hold;

    // Single holding register; a pop in the same cycle makes room for a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
        end else if (w_push && (!r_valid || w_pop)) begin
            r_hold  <= w_byte;
            r_valid <= 1'b1;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_team_06_spi_from_esp.sv
// Directed bench for team_06_spi_from_esp with a byte scoreboard.
// Define TEAM06_SPI_RX_FIFO_EN to exercise the FIFO overrun case instead of
// the holding-register cases.
module tb_team_06_spi_from_esp;
    logic       clk = 1'b0;
    logic       rst;
    logic       spiclk;
    logic       past_spiclk;
    logic       cs;
    logic       serial_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         fe0;
    int         ov0;
    logic [7:0] q [$];
    logic [7:0] exp_b;

    team_06_spi_from_esp #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spiclk      (spiclk),
        .past_spiclk (past_spiclk),
        .cs          (cs),
        .serial_in   (serial_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Models the one-cycle delayed copy of the synchronised spiclk.
    always @(posedge clk) past_spiclk <= spiclk;

    // Scoreboard monitor: every handshake pops the oldest expected byte.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (rx_valid && rx_ready) begin
                n_assert++;
                if (q.size() == 0) begin
                    n_fail++;
                    $error("FAIL unexpected_pop observed %h required no byte", rx_data);
                end else begin
                    exp_b = q.pop_front();
                    assert (rx_data === exp_b) else begin
                        n_fail++;
                        $error("FAIL pop_data observed %h required %h", rx_data, exp_b);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic pop_on_rise);
        @(negedge clk);
        serial_in = b;
        spiclk    = 1'b1;
        if (pop_on_rise) rx_ready = 1'b1;
        @(negedge clk);
        if (pop_on_rise) rx_ready = 1'b0;
        @(negedge clk);
        spiclk = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic expect_it, input logic pop_last);
        if (expect_it) q.push_back(v);
        for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
        send_bit(v[0], pop_last);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        rx_ready = 1'b1;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        rx_ready = 1'b0;
        chk({tag, "_drained"}, q.size(), 0);
        repeat (2) @(negedge clk);
        chk({tag, "_empty_after"}, rx_valid, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        spiclk    = 1'b0;
        cs        = 1'b1;
        serial_in = 1'b0;
        rx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_valid",  rx_valid,  1'b0);
        chk("rst_rx_data",   rx_data,   8'h00);
        chk("rst_overrun",   overrun,   1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Byte A7 with exact rx_valid latency.
        cs_low();
        for (int i = 7; i >= 1; i--) send_bit(1'((8'hA7 >> i) & 8'h01), 1'b0);
        @(negedge clk);
        serial_in = 1'b1;
        spiclk    = 1'b1;
        chk("a7_valid_before_rise", rx_valid, 1'b0);
        @(negedge clk);
        chk("a7_valid_after_rise", rx_valid, 1'b1);
        chk("a7_data", rx_data, 8'hA7);
        @(negedge clk);
        spiclk = 1'b0;
        @(negedge clk);
        q.push_back(8'hA7);
        drain("a7");
        fe0 = fe_cnt;
        cs_high();
        chk("a7_no_frame_err", fe_cnt - fe0, 0);

        // Back-to-back 3C, C3 with consumer always ready.
        fe0 = fe_cnt;
        rx_ready = 1'b1;
        cs_low();
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'hC3, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("b2b_all_popped", q.size(), 0);
        rx_ready = 1'b0;
        cs_high();
        chk("b2b_no_frame_err", fe_cnt - fe0, 0);

        // Partial byte then cs release, followed by a clean 55.
        fe0 = fe_cnt;
        cs_low();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        cs_high();
        chk("partial_frame_err_once", fe_cnt - fe0, 1);
        chk("partial_no_valid", rx_valid, 1'b0);
        cs_low();
        send_byte(8'h55, 1'b1, 1'b0);
        drain("b55");
        cs_high();
        chk("b55_no_extra_frame_err", fe_cnt - fe0, 1);

`ifdef TEAM06_SPI_RX_FIFO_EN
        // Five bytes into a depth-4 FIFO with no consumer.
        ov0 = ov_cnt;
        cs_low();
        for (int b = 1; b <= 5; b++) send_byte(8'(b), (b <= 4), 1'b0);
        chk("fifo_overrun_once", ov_cnt - ov0, 1);
        drain("fifo");
        cs_high();
`else
        // Holding register: second byte dropped while full.
        ov0 = ov_cnt;
        cs_low();
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        chk("hold_overrun_once", ov_cnt - ov0, 1);
        chk("hold_keeps_first", rx_data, 8'h11);
        drain("hold_a");
        // Pop in the same cycle as the second push: both accepted.
        ov0 = ov_cnt;
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b1);
        chk("hold_swap_no_overrun", ov_cnt - ov0, 0);
        chk("hold_swap_valid", rx_valid, 1'b1);
        chk("hold_swap_data", rx_data, 8'h22);
        drain("hold_b");
        cs_high();
`endif

        // Reset mid-byte with one byte buffered.
        cs_low();
        send_byte(8'h9A, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid", rx_valid, 1'b0);
        chk("midrst_data", rx_data, 8'h00);
        cs = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        repeat (3) @(negedge clk);
        chk("rst_release_no_fe", fe_cnt - fe0, 0);
        chk("rst_release_no_ov", ov_cnt - ov0, 0);
        chk("rst_release_no_valid", rx_valid, 1'b0);
        cs_low();
        send_byte(8'hF0, 1'b1, 1'b0);
        drain("f0");
        cs_high();
        chk("f0_no_frame_err", fe_cnt - fe0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit so the run always ends on its own.
    initial begin
        #500000;
        $display("FAIL timeout observed no finish required finish");
        $fatal(1, "timeout");
    end
endmodule
